// File: rtl/overflow_exception_unit.sv
// Raises the MIPS arithmetic-overflow exception (Ov) from the EX stage and handles EXL/ERET redirects.
// Optional masked-overflow counter enabled by defining OVF_MASKED_COUNT_EN.
module overflow_exception_unit #(
    parameter int unsigned       DATA_W      = 32,
    parameter logic [DATA_W-1:0] EXC_VECTOR  = 32'h80000180,
    parameter logic [4:0]        EXC_CODE_OV = 5'd12,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_ovf_en,
    input  logic              ex_overflow,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic              stall,
    input  logic              eret,
    output logic              ex_kill,
    output logic              flush,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] epc,
    output logic [4:0]        cause_code,
    output logic              exl,
    output logic [CNT_W-1:0]  exc_count
`ifdef OVF_MASKED_COUNT_EN
    ,
    output logic [CNT_W-1:0]  masked_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    logic [4:0]        cause_q, cause_d;
    logic              exl_q, exl_d;
    logic [CNT_W-1:0]  exc_count_q, exc_count_d;
    logic              flush_q, flush_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

    logic ovf_req;
    logic trigger;

    // An overflow request is a trapping, real, advancing instruction that overflowed;
    // it only becomes an exception when no exception is already in flight.
    always_comb begin
        ovf_req = ex_valid & ex_ovf_en & ex_overflow & ~stall;
        trigger = ovf_req & ~exl_q & (state_q == ST_IDLE);
        ex_kill = trigger & ~reset;
    end

    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        exl_d       = exl_q;
        exc_count_d = exc_count_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_TAKE;
                    epc_d   = ex_pc;
                    cause_d = EXC_CODE_OV;
                    exl_d   = 1'b1;
                    if (exc_count_q != CNT_MAX) begin
                        exc_count_d = exc_count_q + CNT_ONE;
                    end
                end
            end
            ST_TAKE: begin
                state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                // eret beats a same-cycle overflow, which is masked by exl anyway
                if (eret) begin
                    exl_d   = 1'b0;
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // redirect_valid is a one-cycle command with no ready: the PC logic must load
    // redirect_pc in the cycle redirect_valid is high; redirect_pc reads 0 otherwise.
    always_comb begin
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        if (state_d == ST_TAKE) begin
            flush_d          = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = EXC_VECTOR;
        end else if (state_d == ST_RETURN) begin
            flush_d          = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = epc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            epc_q            <= '0;
            cause_q          <= '0;
            exl_q            <= 1'b0;
            exc_count_q      <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            epc_q            <= epc_d;
            cause_q          <= cause_d;
            exl_q            <= exl_d;
            exc_count_q      <= exc_count_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

`ifdef OVF_MASKED_COUNT_EN
    logic [CNT_W-1:0] masked_count_q, masked_count_d;

    // Overflows that were suppressed because an exception was already in progress
    always_comb begin
        masked_count_d = masked_count_q;
        if (ovf_req & ~trigger & (masked_count_q != CNT_MAX)) begin
            masked_count_d = masked_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            masked_count_q <= '0;
        end else begin
            masked_count_q <= masked_count_d;
        end
    end

    assign masked_count = masked_count_q;
`endif

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign epc            = epc_q;
    assign cause_code     = cause_q;
    assign exl            = exl_q;
    assign exc_count      = exc_count_q;

endmodule
